// File: rtl/exp_result_collector.sv
// Result collector for the exp/Taylor pipeline: buffers finished bundles in a FIFO with a valid/ready output port.
// Optional build macro SATURATE_OVF_EN: overflowed entries store y = all ones instead of the raw accumulator.
module exp_result_collector #(
   parameter int unsigned DEPTH  = 4,
   parameter logic [3:0]  LAST_N = 4'd15,
   parameter int unsigned CNT_W  = 16
) (
   input  logic                     clk,
   input  logic                     rst_n,
   input  logic                     in_valid,
   input  logic                     in_ovf,
   input  logic [7:0]               in_x,
   input  logic [31:0]              in_y,
   input  logic [3:0]               in_n,
   output logic                     in_ready,
   output logic                     out_valid,
   input  logic                     out_ready,
   output logic [7:0]               out_x,
   output logic [31:0]              out_y,
   output logic                     out_ovf,
   output logic [$clog2(DEPTH):0]   count,
   output logic [CNT_W-1:0]         result_cnt,
   output logic [CNT_W-1:0]         ovf_cnt,
   output logic [CNT_W-1:0]         reject_cnt
);

   localparam int unsigned AW = $clog2(DEPTH);
   localparam int unsigned CW = AW + 1;

   typedef struct packed {
      logic [7:0]  x;
      logic [31:0] y;
      logic        ovf;
   } entry_t;

   entry_t          mem [DEPTH];
   entry_t          wr_data;
   entry_t          head;
   logic [AW-1:0]   rd_ptr;
   logic [AW-1:0]   wr_ptr;
   logic            accept;
   logic            push;
   logic            reject;
   logic            pop;

   // Handshake depends only on registered occupancy, never on in_* or out_ready.
   assign in_ready  = (count != CW'(DEPTH));
   assign out_valid = (count != CW'(0));

   assign accept = in_valid & in_ready;
   assign push   = accept & (in_n == LAST_N);
   assign reject = accept & (in_n != LAST_N);
   assign pop    = out_valid & out_ready;

   always_comb begin
      wr_data.x   = in_x;
      wr_data.ovf = in_ovf;
`ifdef SATURATE_OVF_EN
      wr_data.y   = in_ovf ? 32'hFFFF_FFFF : in_y;
`else
      wr_data.y   = in_y;
`endif
   end

   assign head    = mem[rd_ptr];
   assign out_x   = head.x;
   assign out_y   = head.y;
   assign out_ovf = head.ovf;

   // Storage, pointers and occupancy; clearing the array makes the post-reset head read as zero.
   always_ff @(posedge clk) begin
      if (!rst_n) begin
         rd_ptr <= '0;
         wr_ptr <= '0;
         count  <= '0;
         for (int unsigned i = 0; i < DEPTH; i++) begin
            mem[i] <= '0;
         end
      end else begin
         if (push) begin
            mem[wr_ptr] <= wr_data;
            wr_ptr      <= wr_ptr + AW'(1);
         end
         if (pop) begin
            rd_ptr <= rd_ptr + AW'(1);
         end
         count <= count + CW'(push) - CW'(pop);
      end
   end

   // Saturating status counters.
   always_ff @(posedge clk) begin
      if (!rst_n) begin
         result_cnt <= '0;
         ovf_cnt    <= '0;
         reject_cnt <= '0;
      end else begin
         if (push && (result_cnt != '1)) begin
            result_cnt <= result_cnt + CNT_W'(1);
         end
         if (push && in_ovf && (ovf_cnt != '1)) begin
            ovf_cnt <= ovf_cnt + CNT_W'(1);
         end
         if (reject && (reject_cnt != '1)) begin
            reject_cnt <= reject_cnt + CNT_W'(1);
         end
      end
   end

endmodule

// File: tb/tb_exp_result_collector.sv
// Self-checking bench for exp_result_collector: queue-based reference model, per-cycle compare, directed and random stimulus.
module tb_exp_result_collector;

   localparam int unsigned DEPTH = 4;
   localparam int unsigned CNT_W = 5;
   localparam int          CMAX  = (1 << CNT_W) - 1;

   logic                   clk = 1'b0;
   logic                   rst_n;
   logic                   in_valid;
   logic                   in_ovf;
   logic [7:0]             in_x;
   logic [31:0]            in_y;
   logic [3:0]             in_n;
   logic                   in_ready;
   logic                   out_valid;
   logic                   out_ready;
   logic [7:0]             out_x;
   logic [31:0]            out_y;
   logic                   out_ovf;
   logic [2:0]             count;
   logic [CNT_W-1:0]       result_cnt;
   logic [CNT_W-1:0]       ovf_cnt;
   logic [CNT_W-1:0]       reject_cnt;

   int errors = 0;
   int checks = 0;
   bit chk_en = 1'b0;

   exp_result_collector #(.DEPTH(DEPTH), .LAST_N(4'd15), .CNT_W(CNT_W)) dut (
      .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ovf(in_ovf), .in_x(in_x), .in_y(in_y),
      .in_n(in_n), .in_ready(in_ready), .out_valid(out_valid), .out_ready(out_ready), .out_x(out_x),
      .out_y(out_y), .out_ovf(out_ovf), .count(count), .result_cnt(result_cnt), .ovf_cnt(ovf_cnt),
      .reject_cnt(reject_cnt)
   );

   always #5 clk = ~clk;

   task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
      end
   endtask

   // Reference model: a plain queue of stored entries plus saturating integer counters.
   typedef struct {
      logic [7:0]  x;
      logic [31:0] y;
      logic        ovf;
   } ent_t;

   ent_t mq[$];
   int   m_res = 0;
   int   m_ovf = 0;
   int   m_rej = 0;

   always @(posedge clk) begin
      if (!rst_n) begin
         mq.delete();
         m_res = 0;
         m_ovf = 0;
         m_rej = 0;
      end else begin
         bit   can_acc;
         bit   do_pop;
         ent_t e;
         can_acc = in_valid && (mq.size() < DEPTH);
         do_pop  = (mq.size() > 0) && out_ready;
         if (do_pop) void'(mq.pop_front());
         if (can_acc && in_n == 4'd15) begin
            e.x   = in_x;
            e.ovf = in_ovf;
`ifdef SATURATE_OVF_EN
            e.y   = in_ovf ? 32'hFFFF_FFFF : in_y;
`else
            e.y   = in_y;
`endif
            mq.push_back(e);
            if (m_res < CMAX) m_res++;
            if (in_ovf && m_ovf < CMAX) m_ovf++;
         end else if (can_acc) begin
            if (m_rej < CMAX) m_rej++;
         end
      end
   end

   // Per-cycle compare against the model, away from the active edge.
   always @(negedge clk) begin
      if (chk_en) begin
         chk("count", 64'(count), 64'(mq.size()));
         chk("in_ready", 64'(in_ready), 64'(mq.size() != DEPTH));
         chk("out_valid", 64'(out_valid), 64'(mq.size() != 0));
         chk("result_cnt", 64'(result_cnt), 64'(m_res));
         chk("ovf_cnt", 64'(ovf_cnt), 64'(m_ovf));
         chk("reject_cnt", 64'(reject_cnt), 64'(m_rej));
         if (mq.size() != 0) begin
            chk("out_x", 64'(out_x), 64'(mq[0].x));
            chk("out_y", 64'(out_y), 64'(mq[0].y));
            chk("out_ovf", 64'(out_ovf), 64'(mq[0].ovf));
         end
      end
   end

   initial begin
      // Reset held two cycles with a valid bundle present
      rst_n = 1'b0; in_valid = 1'b1; in_n = 4'd15; in_x = 8'hAA; in_y = 32'hDEAD_BEEF;
      in_ovf = 1'b1; out_ready = 1'b0;
      @(negedge clk); @(negedge clk);
      chk("rst_count", 64'(count), 64'd0);
      chk("rst_out_valid", 64'(out_valid), 64'd0);
      chk("rst_in_ready", 64'(in_ready), 64'd1);
      chk("rst_result_cnt", 64'(result_cnt), 64'd0);
      chk("rst_ovf_cnt", 64'(ovf_cnt), 64'd0);
      chk("rst_reject_cnt", 64'(reject_cnt), 64'd0);
      chk("rst_out_y", 64'(out_y), 64'd0);
      chk_en = 1'b1;
      rst_n = 1'b1; in_valid = 1'b0; in_ovf = 1'b0;

      // Single push, latency one
      @(negedge clk);
      in_valid = 1'b1; in_n = 4'd15; in_x = 8'h05; in_y = 32'h0000_0094; in_ovf = 1'b0;
      @(negedge clk);
      in_valid = 1'b0;
      chk("single_out_valid", 64'(out_valid), 64'd1);
      chk("single_out_x", 64'(out_x), 64'h05);
      chk("single_out_y", 64'(out_y), 64'h94);
      chk("single_result_cnt", 64'(result_cnt), 64'd1);
      out_ready = 1'b1;
      @(negedge clk);
      out_ready = 1'b0;
      chk("single_drained", 64'(count), 64'd0);

      // Fill to DEPTH, hold a fifth bundle, free one slot
      for (int i = 1; i <= 4; i++) begin
         in_valid = 1'b1; in_x = 8'(i); in_y = 32'(i * 3);
         @(negedge clk);
      end
      chk("full_in_ready", 64'(in_ready), 64'd0);
      chk("full_count", 64'(count), 64'd4);
      in_x = 8'd5; in_y = 32'd15;
      @(negedge clk); @(negedge clk);
      chk("full_hold_count", 64'(count), 64'd4);
      chk("full_hold_result", 64'(result_cnt), 64'd5);
      out_ready = 1'b1;
      @(negedge clk);
      out_ready = 1'b0;
      chk("full_pop_head", 64'(out_x), 64'd2);
      chk("full_pop_count", 64'(count), 64'd3);
      @(negedge clk);
      in_valid = 1'b0;
      chk("full_late_push", 64'(count), 64'd4);
      chk("full_late_result", 64'(result_cnt), 64'd6);
      out_ready = 1'b1;
      for (int i = 2; i <= 5; i++) begin
         chk("full_order", 64'(out_x), 64'(i));
         @(negedge clk);
      end
      out_ready = 1'b0;
      chk("full_drained", 64'(count), 64'd0);

      // Simultaneous push and pop at occupancy 2
      in_valid = 1'b1; in_x = 8'd20;
      @(negedge clk);
      in_x = 8'd21;
      @(negedge clk);
      out_ready = 1'b1;
      for (int i = 0; i < 10; i++) begin
         in_x = 8'(30 + i); in_y = 32'(1000 + i);
         @(negedge clk);
         chk("pp_count", 64'(count), 64'd2);
      end
      chk("pp_result", 64'(result_cnt), 64'd18);
      in_valid = 1'b0;
      @(negedge clk); @(negedge clk);
      out_ready = 1'b0;
      chk("pp_drained", 64'(count), 64'd0);

      // Overflowed bundle
      in_valid = 1'b1; in_x = 8'h55; in_y = 32'h1234_5678; in_ovf = 1'b1;
      @(negedge clk);
      in_valid = 1'b0; in_ovf = 1'b0;
`ifdef SATURATE_OVF_EN
      chk("ovf_out_y", 64'(out_y), 64'hFFFF_FFFF);
`else
      chk("ovf_out_y", 64'(out_y), 64'h1234_5678);
`endif
      chk("ovf_out_ovf", 64'(out_ovf), 64'd1);
      chk("ovf_cnt", 64'(ovf_cnt), 64'd1);
      out_ready = 1'b1;
      @(negedge clk);
      out_ready = 1'b0;

      // Rejected iteration index, then reset with entries buffered
      in_valid = 1'b1; in_n = 4'd7;
      @(negedge clk);
      in_valid = 1'b0; in_n = 4'd15;
      chk("rej_out_valid", 64'(out_valid), 64'd0);
      chk("rej_cnt", 64'(reject_cnt), 64'd1);
      chk("rej_result", 64'(result_cnt), 64'd19);
      in_valid = 1'b1;
      @(negedge clk); @(negedge clk); @(negedge clk);
      in_valid = 1'b0;
      chk("pre_rst_count", 64'(count), 64'd3);
      rst_n = 1'b0;
      @(negedge clk);
      rst_n = 1'b1;
      chk("mid_rst_count", 64'(count), 64'd0);
      chk("mid_rst_valid", 64'(out_valid), 64'd0);
      chk("mid_rst_result", 64'(result_cnt), 64'd0);

      // Random traffic, including counter saturation and rare resets
      for (int c = 0; c < 3000; c++) begin
         in_valid  = ($urandom % 4) != 0;
         in_n      = (($urandom % 5) == 0) ? 4'($urandom) : 4'd15;
         in_x      = 8'($urandom);
         in_y      = $urandom;
         in_ovf    = ($urandom % 4) == 0;
         out_ready = ($urandom % 3) != 0;
         rst_n     = ($urandom % 700) != 0;
         @(negedge clk);
      end
      rst_n = 1'b1; in_valid = 1'b0; out_ready = 1'b0;
      @(negedge clk);
      chk_en = 1'b0;
      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule
